pgm_ddram_rd_bridge: RTL and testbench



---
 rtl/pgm_ddram_rd_bridge_if.sv | 32 +++
 rtl/pgm_ddram_rd_bridge.sv | 125 ++++++++++++
 tb/tb_pgm_ddram_rd_bridge.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/pgm_ddram_rd_bridge_if.sv
// Client read port plus Avalon-MM master port of the DDRAM read bridge.
// The slave modport is the bridge; the master modport is the client/memory side.
interface pgm_ddram_rd_bridge_if;
    localparam int unsigned AW = 29;
    localparam int unsigned DW = 64;

    logic          ddram_rd;
    logic [AW-1:0] ddram_addr;
    logic          ddram_busy;
    logic [DW-1:0] ddram_dout;
    logic          ddram_dout_valid;
    logic          flush;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_burstcnt;
    logic          mem_busy;
    logic [DW-1:0] mem_dout;
    logic          mem_dout_ready;
    logic [15:0]   miss_count;

    modport slave (
        input  ddram_rd, ddram_addr, flush, mem_busy, mem_dout, mem_dout_ready,
        output ddram_busy, ddram_dout, ddram_dout_valid, mem_rd, mem_addr,
               mem_burstcnt, miss_count
    );

    modport master (
        output ddram_rd, ddram_addr, flush, mem_busy, mem_dout, mem_dout_ready,
        input  ddram_busy, ddram_dout, ddram_dout_valid, mem_rd, mem_addr,
               mem_burstcnt, miss_count
    );
endinterface

// File: rtl/pgm_ddram_rd_bridge.sv
// DDRAM read bridge: one-line cache in front of a single-beat Avalon-MM read port.
// Hits return in one cycle; misses fetch ROM_BASE+addr and refill the line.
module pgm_ddram_rd_bridge #(
    parameter logic [28:0] ROM_BASE = 29'h0300000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    pgm_ddram_rd_bridge_if.slave   bus
);
    localparam int unsigned AW = 29;
    localparam int unsigned DW = 64;
    localparam int unsigned CW = 16;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA} state_e;

    state_e        state_q, state_d;
    logic          busy_q, busy_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          dout_valid_q, dout_valid_d;
    logic          mem_rd_q, mem_rd_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] line_q, line_d;
    logic [AW-1:0] tag_q, tag_d;
    logic          line_valid_q, line_valid_d;
    logic [AW-1:0] req_addr_q, req_addr_d;
    logic          nocache_q, nocache_d;
    logic [CW-1:0] miss_q, miss_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_addr_q   <= '0;
            line_q       <= '0;
            tag_q        <= '0;
            line_valid_q <= 1'b0;
            req_addr_q   <= '0;
            nocache_q    <= 1'b0;
            miss_q       <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            mem_rd_q     <= mem_rd_d;
            mem_addr_q   <= mem_addr_d;
            line_q       <= line_d;
            tag_q        <= tag_d;
            line_valid_q <= line_valid_d;
            req_addr_q   <= req_addr_d;
            nocache_q    <= nocache_d;
            miss_q       <= miss_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        mem_rd_d     = mem_rd_q;
        mem_addr_d   = mem_addr_q;
        line_d       = line_q;
        tag_d        = tag_q;
        line_valid_d = line_valid_q;
        req_addr_d   = req_addr_q;
        nocache_d    = nocache_q;
        miss_d       = miss_q;

        if (bus.flush) line_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.ddram_rd) begin
                    // A flush on the accept edge invalidates the line before the lookup
                    if (line_valid_q && (tag_q == bus.ddram_addr) && !bus.flush) begin
                        dout_d       = line_q;
                        dout_valid_d = 1'b1;
                    end else begin
                        state_d    = ISSUE;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = AW'(ROM_BASE + bus.ddram_addr);
                        req_addr_d = bus.ddram_addr;
                        nocache_d  = 1'b0;
                        if (miss_q != {CW{1'b1}}) miss_d = miss_q + CW'(1);
                    end
                end
            end
            ISSUE: begin
                if (bus.flush) nocache_d = 1'b1;
                if (!bus.mem_busy) begin
                    mem_rd_d = 1'b0;
                    state_d  = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (bus.flush) nocache_d = 1'b1;
                if (bus.mem_dout_ready) begin
                    dout_d       = bus.mem_dout;
                    dout_valid_d = 1'b1;
                    state_d      = IDLE;
                    // Data fetched across a flush may be stale, so it is delivered but not kept
                    if (!(nocache_q || bus.flush)) begin
                        line_d       = bus.mem_dout;
                        tag_d        = req_addr_q;
                        line_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.ddram_busy       = busy_q;
    assign bus.ddram_dout       = dout_q;
    assign bus.ddram_dout_valid = dout_valid_q;
    assign bus.mem_rd           = mem_rd_q;
    assign bus.mem_addr         = mem_addr_q;
    assign bus.mem_burstcnt     = 8'd1;
    assign bus.miss_count       = miss_q;
endmodule

// File: tb/tb_pgm_ddram_rd_bridge.sv
// Self-checking bench for pgm_ddram_rd_bridge: directed cases then random traffic
// against a transaction-level cache model.
module tb_pgm_ddram_rd_bridge;
    localparam logic [28:0] BASE = 29'h0300000;

    logic clk = 1'b0;
    logic reset_n;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_rd_obs = 0;
    int   n_rd_exp = 0;

    // transaction-level model state
    bit          m_valid;
    logic [28:0] m_tag;
    logic [63:0] m_data;
    logic [63:0] m_last;
    int          m_miss;

    pgm_ddram_rd_bridge_if b ();
    pgm_ddram_rd_bridge_if b2 ();

    pgm_ddram_rd_bridge #(.ROM_BASE(BASE)) dut (
        .clk(clk), .reset_n(reset_n), .bus(b)
    );
    pgm_ddram_rd_bridge #(.ROM_BASE(29'h1FFFFFFF)) dut_wrap (
        .clk(clk), .reset_n(reset_n), .bus(b2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (b.mem_rd && !b.mem_busy) n_rd_obs++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one client request; waits = waitrequest cycles, lat = idle cycles before readdatavalid
    task automatic access(input logic [28:0] a, input bit fl_now, input int waits,
                          input int lat, input bit fl_mid, input logic [63:0] data);
        logic [28:0] ea;
        bit hit;
        chk("busy_before_req", b.ddram_busy, 1'b0);
        hit = m_valid && (m_tag == a) && !fl_now;
        if (fl_now) m_valid = 1'b0;
        b.ddram_rd = 1'b1; b.ddram_addr = a; b.flush = fl_now;
        b.mem_busy = (waits > 0);
        step();
        b.ddram_rd = 1'b0; b.flush = 1'b0;
        if (hit) begin
            m_last = m_data;
            chk("hit_valid", b.ddram_dout_valid, 1'b1);
            chk("hit_dout", b.ddram_dout, m_data);
            chk("hit_no_memrd", b.mem_rd, 1'b0);
            chk("hit_busy", b.ddram_busy, 1'b0);
            chk("hit_miss_cnt", b.miss_count, 64'(m_miss));
            return;
        end
        if (m_miss < 65535) m_miss++;
        n_rd_exp++;
        ea = 29'(BASE + a);
        chk("miss_memrd", b.mem_rd, 1'b1);
        chk("miss_memaddr", b.mem_addr, ea);
        chk("miss_busy", b.ddram_busy, 1'b1);
        chk("miss_novalid", b.ddram_dout_valid, 1'b0);
        chk("miss_cnt", b.miss_count, 64'(m_miss));
        for (int i = 0; i < waits; i++) begin
            step();
            chk("wait_memrd", b.mem_rd, 1'b1);
            chk("wait_memaddr", b.mem_addr, ea);
        end
        b.mem_busy = 1'b0;
        step();
        chk("taken_memrd", b.mem_rd, 1'b0);
        chk("wait_busy", b.ddram_busy, 1'b1);
        for (int i = 0; i < lat; i++) begin
            b.flush = fl_mid && (i == 0);
            step();
            b.flush = 1'b0;
            chk("lat_novalid", b.ddram_dout_valid, 1'b0);
        end
        b.mem_dout_ready = 1'b1; b.mem_dout = data;
        if (lat == 0) b.flush = fl_mid;
        step();
        b.mem_dout_ready = 1'b0; b.flush = 1'b0;
        b.mem_dout = 64'hDEAD_BEEF_DEAD_BEEF;
        chk("fill_valid", b.ddram_dout_valid, 1'b1);
        chk("fill_dout", b.ddram_dout, data);
        chk("fill_busy", b.ddram_busy, 1'b0);
        m_last = data;
        if (fl_mid) m_valid = 1'b0;
        else begin m_valid = 1'b1; m_tag = a; m_data = data; end
    endtask

    task automatic idle_check(input string tag);
        step();
        chk({tag, "_valid_low"}, b.ddram_dout_valid, 1'b0);
        chk({tag, "_dout_hold"}, b.ddram_dout, m_last);
    endtask

    initial begin
        reset_n = 1'b0;
        b.ddram_rd = 1'b0; b.ddram_addr = '0; b.flush = 1'b0;
        b.mem_busy = 1'b0; b.mem_dout = '0; b.mem_dout_ready = 1'b0;
        b2.ddram_rd = 1'b1; b2.ddram_addr = 29'h2; b2.flush = 1'b0;
        b2.mem_busy = 1'b0; b2.mem_dout = '0; b2.mem_dout_ready = 1'b0;
        m_valid = 1'b0; m_tag = '0; m_data = '0; m_last = '0; m_miss = 0;
        step(); step();
        chk("rst_busy", b.ddram_busy, 1'b0);
        chk("rst_dout", b.ddram_dout, 64'h0);
        chk("rst_valid", b.ddram_dout_valid, 1'b0);
        chk("rst_memrd", b.mem_rd, 1'b0);
        chk("rst_memaddr", b.mem_addr, 29'h0);
        chk("rst_burstcnt", b.mem_burstcnt, 8'd1);
        chk("rst_miss", b.miss_count, 16'd0);
        reset_n = 1'b1;

        step();
        b2.ddram_rd = 1'b0;
        chk("wrap_memrd", b2.mem_rd, 1'b1);
        chk("wrap_memaddr", b2.mem_addr, 29'h0000001);

        // first miss, then three back-to-back hits
        access(29'h10, 1'b0, 0, 4, 1'b0, 64'hA5A5_A5A5_A5A5_A5A5);
        chk("first_miss_cnt", b.miss_count, 16'd1);
        for (int i = 0; i < 3; i++) access(29'h10, 1'b0, 0, 0, 1'b0, 64'h0);
        idle_check("after_hits");
        chk("hits_miss_cnt", b.miss_count, 16'd1);

        // long waitrequest: one Avalon read only
        access(29'h44, 1'b0, 5, 1, 1'b0, 64'h1122_3344_5566_7788);
        chk("waitreq_reads", 64'(n_rd_obs), 64'(n_rd_exp));
        idle_check("after_waitreq");

        // stray readdatavalid while idle
        b.mem_dout_ready = 1'b1; b.mem_dout = 64'hBAD0_BAD0_BAD0_BAD0;
        step();
        b.mem_dout_ready = 1'b0;
        chk("stray_idle_valid", b.ddram_dout_valid, 1'b0);
        chk("stray_idle_dout", b.ddram_dout, m_last);
        access(29'h44, 1'b0, 0, 0, 1'b0, 64'h0);

        // flush while waiting for data, then same address must miss
        access(29'h55, 1'b0, 0, 2, 1'b1, 64'hCAFE_0000_CAFE_0001);
        access(29'h55, 1'b0, 1, 0, 1'b0, 64'hCAFE_0000_CAFE_0002);
        access(29'h55, 1'b0, 0, 0, 1'b0, 64'h0);
        // flush coinciding with an otherwise-hitting request
        access(29'h55, 1'b1, 0, 1, 1'b0, 64'hCAFE_0000_CAFE_0003);
        access(29'h55, 1'b0, 0, 0, 1'b0, 64'h0);

        // random traffic against the model
        for (int n = 0; n < 60; n++) begin
            access(29'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   ($urandom_range(0, 9) == 0), {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) idle_check("rand_idle");
        end
        chk("rand_reads", 64'(n_rd_obs), 64'(n_rd_exp));

        // reset during WAIT_DATA, then a late readdatavalid
        b.ddram_rd = 1'b1; b.ddram_addr = 29'h20;
        step();
        b.ddram_rd = 1'b0;
        n_rd_exp++;
        step();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", b.ddram_busy, 1'b0);
        chk("mid_rst_dout", b.ddram_dout, 64'h0);
        chk("mid_rst_memrd", b.mem_rd, 1'b0);
        chk("mid_rst_memaddr", b.mem_addr, 29'h0);
        chk("mid_rst_miss", b.miss_count, 16'd0);
        m_valid = 1'b0; m_miss = 0; m_last = '0;
        step();
        reset_n = 1'b1;
        b.mem_dout_ready = 1'b1; b.mem_dout = 64'h5555_AAAA_5555_AAAA;
        step();
        b.mem_dout_ready = 1'b0;
        chk("late_ready_valid", b.ddram_dout_valid, 1'b0);
        chk("late_ready_dout", b.ddram_dout, 64'h0);
        chk("late_ready_busy", b.ddram_busy, 1'b0);
        access(29'h10, 1'b0, 0, 1, 1'b0, 64'h0F0F_0F0F_0F0F_0F0F);
        chk("post_rst_miss", b.miss_count, 16'd1);
        chk("final_reads", 64'(n_rd_obs), 64'(n_rd_exp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
